irom_arbiter: RTL and testbench

//  Shares the single combinational instruction-ROM read port between two masters:
//  M0 = instruction fetch, M1 = data load (.rodata). Arbitrates, drives rom_haddr,

---
 rtl/irom_pkg.sv | 24 ++
 rtl/irom_arb_pick.sv | 24 ++
 rtl/irom_arbiter.sv | 137 +++++++++++++
 tb/tb_irom_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/irom_pkg.sv
// Shared definitions for the instruction-ROM arbiter: ROM window defaults,
// FSM state encoding, master ids and the address window check.
// Optional feature macro: IROM_ARB_RR_EN (round-robin tie breaking).
package irom_pkg;

    localparam logic [63:0] ROM_START_DEF = 64'h0;
    localparam logic [63:0] ROM_SIZE_DEF  = 64'd20480;

    typedef enum logic [1:0] {IDLE, READ, RESP} state_t;

    localparam logic M0 = 1'b0;  // instruction fetch
    localparam logic M1 = 1'b1;  // data load (.rodata)

    // A full 8-byte word must fit inside the ROM, so the last 8 bytes are excluded.
    // The lower bound is checked first so addr - start never wraps. Needs size >= 8.
    function automatic logic in_window(input logic [63:0] addr,
                                       input logic [63:0] start,
                                       input logic [63:0] size);
        logic [63:0] offset;
        offset = addr - start;
        return (addr >= start) && (offset < (size - 64'd8));
    endfunction

endpackage

// File: rtl/irom_arb_pick.sv
// Combinational two-way picker. On a tie the port that did not win last time
// is chosen; tying rr_last to M1 turns this into fixed M0 priority.
module irom_arb_pick
    import irom_pkg::*;
(
    input  logic [1:0] req,
    input  logic       rr_last,
    output logic       gnt_id,
    output logic       any
);

    // Pick the winning port id from the request pair
    always_comb begin
        gnt_id = M0;
        any    = |req;
        case (req)
            2'b01:   gnt_id = M0;
            2'b10:   gnt_id = M1;
            2'b11:   gnt_id = ~rr_last;
            default: gnt_id = M0;
        endcase
    end

endmodule

// File: rtl/irom_arbiter.sv
// Shares the combinational instruction-ROM read port between instruction fetch
// (M0) and data load (M1). One access per two cycles: READ drives the ROM and
// grants, RESP returns the registered word. Out-of-window addresses return
// zero data with an error flag so an undriven ROM never reaches a master.
// Optional feature macro: IROM_ARB_RR_EN (round-robin instead of fixed M0 priority).
module irom_arbiter
    import irom_pkg::*;
#(
    parameter logic [63:0] ROM_START = ROM_START_DEF,
    parameter logic [63:0] ROM_SIZE  = ROM_SIZE_DEF
) (
    input  logic        HCLK,
    input  logic        HRESETn,

    input  logic        m0_req,
    input  logic [63:0] m0_addr,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [63:0] m0_rdata,
    output logic        m0_rerr,

    input  logic        m1_req,
    input  logic [63:0] m1_addr,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [63:0] m1_rdata,
    output logic        m1_rerr,

    output logic [63:0] rom_haddr,
    input  logic [63:0] rom_hrdata,
    output logic        busy
);

    state_t      state_q, state_d;
    logic [63:0] addr_q;
    logic        id_q;
    logic [63:0] rdata_q;
    logic        rerr_q;

    logic        rr_last;
    logic        pick_id;
    logic        pick_any;
    logic        arb_edge;
    logic        take;

`ifdef IROM_ARB_RR_EN
    logic rr_last_q;
    assign rr_last = rr_last_q;
`else
    // Pretending M1 always won last keeps M0 ahead on every tie.
    assign rr_last = M1;
`endif

    irom_arb_pick u_pick (
        .req     ({m1_req, m0_req}),
        .rr_last (rr_last),
        .gnt_id  (pick_id),
        .any     (pick_any)
    );

    // Arbitration happens on edges leaving IDLE or RESP; never during READ.
    assign arb_edge = (state_q == IDLE) || (state_q == RESP);
    assign take     = arb_edge && pick_any;

    // Next-state: IDLE -> READ -> RESP -> READ/IDLE
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (pick_any) state_d = READ;
            READ:    state_d = RESP;
            RESP:    state_d = pick_any ? READ : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latch the winner's address and id; addr_q doubles as the held ROM address
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_q <= '0;
            id_q   <= M0;
        end else if (take) begin
            addr_q <= (pick_id == M1) ? m1_addr : m0_addr;
            id_q   <= pick_id;
        end
    end

    // Capture the ROM word at the end of READ, or flag the address as out of window
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rdata_q <= '0;
            rerr_q  <= 1'b0;
        end else if (state_q == READ) begin
            if (in_window(addr_q, ROM_START, ROM_SIZE)) begin
                rdata_q <= rom_hrdata;
                rerr_q  <= 1'b0;
            end else begin
                rdata_q <= '0;
                rerr_q  <= 1'b1;
            end
        end
    end

`ifdef IROM_ARB_RR_EN
    // Remember the last granted port; reset favours M0 on the first tie
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rr_last_q <= M1;
        end else if (take) begin
            rr_last_q <= pick_id;
        end
    end
`endif

    // Output decode from state and latched winner
    always_comb begin
        m0_gnt    = (state_q == READ) && (id_q == M0);
        m1_gnt    = (state_q == READ) && (id_q == M1);
        m0_rvalid = (state_q == RESP) && (id_q == M0);
        m1_rvalid = (state_q == RESP) && (id_q == M1);
        m0_rerr   = m0_rvalid && rerr_q;
        m1_rerr   = m1_rvalid && rerr_q;
        m0_rdata  = rdata_q;
        m1_rdata  = rdata_q;
        rom_haddr = addr_q;
        busy      = (state_q != IDLE);
    end

endmodule

// File: tb/tb_irom_arbiter.sv
// Directed bench for irom_arbiter. ROM model: byte at address a is a[7:0]-8'h0F,
// undriven (Z) at and above 0x5000.
module tb_irom_arbiter;

    logic        HCLK    = 1'b0;
    logic        HRESETn = 1'b1;

    logic        m0_req  = 1'b0;
    logic [63:0] m0_addr = '0;
    logic        m1_req  = 1'b0;
    logic [63:0] m1_addr = '0;
    logic        m0_gnt, m0_rvalid, m0_rerr;
    logic        m1_gnt, m1_rvalid, m1_rerr;
    logic [63:0] m0_rdata, m1_rdata, rom_haddr, rom_hrdata;
    logic        busy;

    // Second instance with a relocated window
    logic        b_m0_req  = 1'b0;
    logic [63:0] b_m0_addr = '0;
    logic        b_m1_req  = 1'b0;
    logic [63:0] b_m1_addr = '0;
    logic        b_m0_gnt, b_m0_rvalid, b_m0_rerr;
    logic        b_m1_gnt, b_m1_rvalid, b_m1_rerr;
    logic [63:0] b_m0_rdata, b_m1_rdata, b_rom_haddr, b_rom_hrdata;
    logic        b_busy;

    int total = 0;
    int bad   = 0;

    always #5 HCLK = ~HCLK;

    function automatic logic [63:0] rom_word(input logic [63:0] a);
        logic [63:0] w;
        if (a >= 64'h5000) return 'z;
        for (int i = 0; i < 8; i++) begin
            logic [7:0] lo;
            lo = a[7:0] + 8'(i);
            w[i*8 +: 8] = lo - 8'h0F;
        end
        return w;
    endfunction

    assign rom_hrdata   = rom_word(rom_haddr);
    assign b_rom_hrdata = rom_word(b_rom_haddr);

    irom_arbiter u_dut (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .m0_req     (m0_req),
        .m0_addr    (m0_addr),
        .m0_gnt     (m0_gnt),
        .m0_rvalid  (m0_rvalid),
        .m0_rdata   (m0_rdata),
        .m0_rerr    (m0_rerr),
        .m1_req     (m1_req),
        .m1_addr    (m1_addr),
        .m1_gnt     (m1_gnt),
        .m1_rvalid  (m1_rvalid),
        .m1_rdata   (m1_rdata),
        .m1_rerr    (m1_rerr),
        .rom_haddr  (rom_haddr),
        .rom_hrdata (rom_hrdata),
        .busy       (busy)
    );

    irom_arbiter #(
        .ROM_START (64'h1000)
    ) u_dut_b (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .m0_req     (b_m0_req),
        .m0_addr    (b_m0_addr),
        .m0_gnt     (b_m0_gnt),
        .m0_rvalid  (b_m0_rvalid),
        .m0_rdata   (b_m0_rdata),
        .m0_rerr    (b_m0_rerr),
        .m1_req     (b_m1_req),
        .m1_addr    (b_m1_addr),
        .m1_gnt     (b_m1_gnt),
        .m1_rvalid  (b_m1_rvalid),
        .m1_rdata   (b_m1_rdata),
        .m1_rerr    (b_m1_rerr),
        .rom_haddr  (b_rom_haddr),
        .rom_hrdata (b_rom_hrdata),
        .busy       (b_busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next;
        @(posedge HCLK);
        #1;
    endtask

    // Hard stop if the sequence ever stalls
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] wins;
        logic       w;
`ifdef IROM_ARB_RR_EN
        wins = 4'b1010;  // bit k = winner of grant k: M0,M1,M0,M1
`else
        wins = 4'b0000;  // M0 every time, M1 starved
`endif

        // ---- reset state
        #1 HRESETn = 1'b0;
        #2;
        chk("rst_m0_gnt",    m0_gnt,    0);
        chk("rst_m1_gnt",    m1_gnt,    0);
        chk("rst_m0_rvalid", m0_rvalid, 0);
        chk("rst_m1_rvalid", m1_rvalid, 0);
        chk("rst_m0_rerr",   m0_rerr,   0);
        chk("rst_rdata",     m0_rdata,  0);
        chk("rst_haddr",     rom_haddr, 0);
        chk("rst_busy",      busy,      0);
        @(posedge HCLK);
        #3 HRESETn = 1'b1;
        next();

        // ---- T2: single M0 read at 0x10
        m0_req = 1'b1; m0_addr = 64'h10;
        chk("t2_no_early_gnt", m0_gnt, 0);
        next();
        chk("t2_m0_gnt",  m0_gnt,    1);
        chk("t2_m1_gnt",  m1_gnt,    0);
        chk("t2_haddr",   rom_haddr, 64'h10);
        chk("t2_busy",    busy,      1);
        m0_req = 1'b0;
        next();
        chk("t2_m0_rvalid", m0_rvalid, 1);
        chk("t2_m1_rvalid", m1_rvalid, 0);
        chk("t2_rdata",     m0_rdata,  64'h0807060504030201);
        chk("t2_rerr",      m0_rerr,   0);
        chk("t2_gnt_gone",  m0_gnt,    0);
        next();
        chk("t2_idle_busy",  busy,      0);
        chk("t2_idle_rv",    m0_rvalid, 0);
        chk("t2_rdata_hold", m0_rdata,  64'h0807060504030201);
        chk("t2_haddr_hold", rom_haddr, 64'h10);

        // ---- T3: M1 out-of-window at the last ROM word and near 2^64
        m1_req = 1'b1; m1_addr = 64'h4FF8;
        next();
        chk("t3a_m1_gnt", m1_gnt, 1);
        m1_req = 1'b0;
        next();
        chk("t3a_m1_rvalid", m1_rvalid, 1);
        chk("t3a_m0_rvalid", m0_rvalid, 0);
        chk("t3a_m1_rerr",   m1_rerr,   1);
        chk("t3a_m1_rdata",  m1_rdata,  0);
        next();
        m1_req = 1'b1; m1_addr = 64'hFFFF_FFFF_FFFF_FFF0;
        next();
        chk("t3b_m1_gnt", m1_gnt, 1);
        m1_req = 1'b0;
        next();
        chk("t3b_m1_rvalid", m1_rvalid, 1);
        chk("t3b_m1_rerr",   m1_rerr,   1);
        chk("t3b_m1_rdata",  m1_rdata,  0);
        next();

        // ---- T6a: highest in-window address
        m0_req = 1'b1; m0_addr = 64'h4FF7;
        next();
        m0_req = 1'b0;
        next();
        chk("t6a_rvalid", m0_rvalid, 1);
        chk("t6a_rerr",   m0_rerr,   0);
        chk("t6a_rdata",  m0_rdata,  64'hEFEEEDECEBEAE9E8);
        next();

        // ---- T1: reset asserted during READ
        m0_req = 1'b1; m0_addr = 64'h10;
        next();
        chk("t1_gnt_before", m0_gnt, 1);
        m0_req = 1'b0;
        #2 HRESETn = 1'b0;
        #1;
        chk("t1_gnt_drop", m0_gnt,    0);
        chk("t1_busy",     busy,      0);
        chk("t1_haddr",    rom_haddr, 0);
        chk("t1_rdata",    m0_rdata,  0);
        @(posedge HCLK);
        #3 HRESETn = 1'b1;
        next();
        chk("t1_no_rvalid_a", m0_rvalid, 0);
        next();
        chk("t1_no_rvalid_b", m0_rvalid, 0);
        chk("t1_idle",        busy,      0);

        // ---- T4: both masters hold requests continuously
        m0_req = 1'b1; m0_addr = 64'h20;
        m1_req = 1'b1; m1_addr = 64'h40;
        for (int k = 0; k < 4; k++) begin
            w = wins[k];
            next();
            chk($sformatf("t4_m0_gnt%0d", k), m0_gnt, {63'd0, ~w});
            chk($sformatf("t4_m1_gnt%0d", k), m1_gnt, {63'd0, w});
            if (k == 3) begin
                m0_req = 1'b0;
                m1_req = 1'b0;
            end
            next();
            chk($sformatf("t4_m0_rv%0d", k), m0_rvalid, {63'd0, ~w});
            chk($sformatf("t4_m1_rv%0d", k), m1_rvalid, {63'd0, w});
            chk($sformatf("t4_rdata%0d", k), m0_rdata,
                w ? 64'h3837363534333231 : 64'h1817161514131211);
        end
        next();
        chk("t4_idle", busy, 0);

        // ---- T5: M0 request arriving during an M1 response
        m1_req = 1'b1; m1_addr = 64'h40;
        next();
        chk("t5_m1_gnt", m1_gnt, 1);
        m1_req = 1'b0;
        next();
        chk("t5_m1_rvalid", m1_rvalid, 1);
        m0_req = 1'b1; m0_addr = 64'h10;
        next();
        chk("t5_m0_gnt_now", m0_gnt, 1);
        chk("t5_busy",       busy,   1);
        m0_req = 1'b0;
        next();
        chk("t5_m0_rvalid", m0_rvalid, 1);
        chk("t5_m0_rdata",  m0_rdata,  64'h0807060504030201);
        next();
        chk("t5_idle", busy, 0);

        // ---- T6b: relocated window, one byte below and exactly at ROM_START
        b_m0_req = 1'b1; b_m0_addr = 64'hFFF;
        next();
        chk("t6b_gnt", b_m0_gnt, 1);
        b_m0_req = 1'b0;
        next();
        chk("t6b_below_rv",   b_m0_rvalid, 1);
        chk("t6b_below_rerr", b_m0_rerr,   1);
        chk("t6b_below_data", b_m0_rdata,  0);
        next();
        b_m0_req = 1'b1; b_m0_addr = 64'h1000;
        next();
        b_m0_req = 1'b0;
        next();
        chk("t6b_base_rv",   b_m0_rvalid, 1);
        chk("t6b_base_rerr", b_m0_rerr,   0);
        chk("t6b_base_data", b_m0_rdata,  64'hF8F7F6F5F4F3F2F1);
        next();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
